// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the add-3 correction threshold.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned ADD3_THRESHOLD = 5;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction.
// Adds 3 to a BCD digit that is 5 or more, so the following shift carries into the next digit.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);
    import bin2bcd_pkg::*;

    always_comb begin
        corrected = digit;
        if (digit >= 4'(ADD3_THRESHOLD)) begin
            corrected = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a fixed latency of BIN_W+1 cycles.
// Results and the overflow flag are registered and held between conversions.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    import bin2bcd_pkg::*;

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] work_q;
    logic [4*DIGITS-1:0] adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                carry_q;
    logic                done_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic                ovf_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .digit     (work_q[4*g +: 4]),
            .corrected (adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin_in;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A set top bit after correction would be shifted out: the value exceeds DIGITS.
                    carry_q <= carry_q | adj[4*DIGITS-1];
                    work_q  <= {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
                    bin_q   <= {bin_q[BIN_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    done_q <= 1'b1;
                    bcd_q  <= work_q;
                    ovf_q  <= carry_q;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 16-bit/5-digit instance and a 14-bit/4-digit instance.
// Expected BCD values and latencies are hand-computed constants.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;
    logic        busy, done, overflow;
    logic [19:0] bcd_out;

    logic        start14;
    logic [13:0] bin14;
    logic        busy14, done14, ovf14;
    logic [15:0] bcd14;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int lat;
    int snap;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (
        .clk      (clk),
        .rst      (rst),
        .start    (start14),
        .bin_in   (bin14),
        .busy     (busy14),
        .done     (done14),
        .bcd_out  (bcd14),
        .overflow (ovf14)
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge just after the accepting edge.
    task automatic go16(input logic [15:0] v);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic go14(input logic [13:0] v);
        @(negedge clk);
        bin14   = v;
        start14 = 1'b1;
        @(negedge clk);
        start14 = 1'b0;
    endtask

    // Counts negedges since the accepting edge until done is seen; -1 if the bound expires.
    task automatic wait16(input int offset, output int k_out);
        k_out = -1;
        for (int k = offset + 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                k_out = k;
                break;
            end
        end
    endtask

    task automatic wait14(output int k_out);
        k_out = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done14) begin
                k_out = k;
                break;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        bin_in  = '0;
        start14 = 1'b0;
        bin14   = '0;
        #3;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_bcd", bcd_out, 0);
        check_eq("rst_ovf", overflow, 0);

        // First edge after reset release accepts the start.
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        bin_in = 16'd65535;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check_eq("first_busy", busy, 1);
        wait16(0, lat);
        check_eq("max_lat", lat, 17);
        check_eq("max_bcd", bcd_out, 32'h65535);
        check_eq("max_ovf", overflow, 0);
        check_eq("max_busy_in_done", busy, 0);
        @(negedge clk);
        check_eq("done_single", done, 0);

        go16(16'd0);
        repeat (5) @(negedge clk);
        check_eq("hold_bcd", bcd_out, 32'h65535);
        wait16(5, lat);
        check_eq("zero_lat", lat, 17);
        check_eq("zero_bcd", bcd_out, 32'h00000);
        check_eq("zero_ovf", overflow, 0);

        go14(14'd9999);
        wait14(lat);
        check_eq("w14_lat", lat, 15);
        check_eq("w14_9999_bcd", bcd14, 32'h9999);
        check_eq("w14_9999_ovf", ovf14, 0);
        go14(14'd16383);
        wait14(lat);
        check_eq("w14_16383_bcd", bcd14, 32'h6383);
        check_eq("w14_16383_ovf", ovf14, 1);
        repeat (3) @(negedge clk);
        check_eq("w14_ovf_hold", ovf14, 1);

        // Start while busy is ignored.
        snap = done_cnt;
        go16(16'd1234);
        repeat (4) @(negedge clk);
        bin_in = 16'd42;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait16(5, lat);
        check_eq("busy_lat", lat, 17);
        check_eq("busy_bcd", bcd_out, 32'h01234);
        repeat (25) @(negedge clk);
        check_eq("busy_one_done", done_cnt - snap, 1);

        // Reset during SHIFT aborts the conversion.
        go16(16'd999);
        repeat (7) @(negedge clk);
        snap = done_cnt;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_bcd", bcd_out, 0);
        check_eq("abort_ovf", overflow, 0);
        check_eq("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check_eq("abort_no_done", done_cnt - snap, 0);
        go16(16'd500);
        wait16(0, lat);
        check_eq("post_abort_bcd", bcd_out, 32'h00500);

        // Back-to-back start in the done cycle.
        go16(16'd300);
        wait16(0, lat);
        check_eq("b2b_first_bcd", bcd_out, 32'h00300);
        bin_in = 16'd77;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check_eq("b2b_busy", busy, 1);
        wait16(0, lat);
        check_eq("b2b_lat", lat, 17);
        check_eq("b2b_bcd", bcd_out, 32'h00077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
